// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default register index / data widths
//   src_e                           : writeback source identifier
//   rr_other()                      : the source that is not the given one
package wb_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    function automatic src_e rr_other(input src_e src);
        return (src == SRC_EXU) ? SRC_LSU : SRC_EXU;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between decode / execution units and the writeback arbiter.
//   issue_*  : decode marks a destination register pending
//   exu_*    : ALU result handshake
//   lsu_*    : load result handshake
//   rf_*     : register-file write port
//   busy     : per-register pending bitmap
// Modports: slave = arbiter side, master = core / testbench side.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                       issue_valid;
    logic [ADDR_WIDTH-1:0]      issue_rd;
    logic                       issue_ready;

    logic                       exu_valid;
    logic                       exu_ready;
    logic [ADDR_WIDTH-1:0]      exu_rd;
    logic [DATA_WIDTH-1:0]      exu_data;

    logic                       lsu_valid;
    logic                       lsu_ready;
    logic [ADDR_WIDTH-1:0]      lsu_rd;
    logic [DATA_WIDTH-1:0]      lsu_data;

    logic                       rf_we;
    logic [ADDR_WIDTH-1:0]      rf_wa;
    logic [DATA_WIDTH-1:0]      rf_wd;

    logic [(2**ADDR_WIDTH)-1:0] busy;

    modport slave (
        input  issue_valid, issue_rd,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, exu_ready, lsu_ready,
        output rf_we, rf_wa, rf_wd, busy
    );

    modport master (
        output issue_valid, issue_rd,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, exu_ready, lsu_ready,
        input  rf_we, rf_wa, rf_wd, busy
    );

endinterface

// File: rtl/wb_arbiter_rr_arb.sv
// Two-requestor round-robin arbiter with last-grant state.
//   clk, rst_n  : clock, async active-low reset
//   req_exu_i   : EXU requests
//   req_lsu_i   : LSU requests
//   gnt_exu_o   : EXU granted (combinational, never together with gnt_lsu_o)
//   gnt_lsu_o   : LSU granted
// Every grant is a transfer, so the last-grant flop follows any grant.
module wb_rr_arb
    import wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_exu_i,
    input  logic req_lsu_i,
    output logic gnt_exu_o,
    output logic gnt_lsu_o
);

    src_e last_q;
    src_e last_d;

    always_comb begin
        gnt_exu_o = 1'b0;
        gnt_lsu_o = 1'b0;
        last_d    = last_q;
        // No grants while reset is held, even though last_q is already forced.
        if (rst_n) begin
            if (req_exu_i && req_lsu_i) begin
                if (rr_other(last_q) == SRC_EXU) begin
                    gnt_exu_o = 1'b1;
                end else begin
                    gnt_lsu_o = 1'b1;
                end
            end else if (req_exu_i) begin
                gnt_exu_o = 1'b1;
            end else if (req_lsu_i) begin
                gnt_lsu_o = 1'b1;
            end
        end
        if (gnt_exu_o) begin
            last_d = SRC_EXU;
        end else if (gnt_lsu_o) begin
            last_d = SRC_LSU;
        end
    end

    // Reset to LSU so the EXU wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_LSU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EXU and LSU results onto one register-file
// write port and tracks pending destination registers.
//   clk, rst_n : clock, async active-low reset
//   bus        : wb_arbiter_if.slave (issue, exu, lsu handshakes, rf write
//                port, busy bitmap)
// One-cycle output stage: a transfer at posedge N writes during cycle N+1.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic                  gnt_exu;
    logic                  gnt_lsu;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  issue_ready;
    logic                  issue_set;

    logic                  rf_we_q,   rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_wa_q,   rf_wa_d;
    logic [DATA_WIDTH-1:0] rf_wd_q,   rf_wd_d;
    logic [NREGS-1:0]      busy_q,    busy_d;

    wb_rr_arb u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_exu_i (bus.exu_valid),
        .req_lsu_i (bus.lsu_valid),
        .gnt_exu_o (gnt_exu),
        .gnt_lsu_o (gnt_lsu)
    );

    // Grants are only raised for a valid requestor, so a grant is a transfer.
    assign xfer          = gnt_exu || gnt_lsu;
    assign bus.exu_ready = gnt_exu;
    assign bus.lsu_ready = gnt_lsu;

    // WAW stall: hold off a new writer of a register that is still pending.
    assign issue_ready     = rst_n && ((bus.issue_rd == '0) || !busy_q[bus.issue_rd]);
    assign issue_set       = bus.issue_valid && issue_ready && (bus.issue_rd != '0);
    assign bus.issue_ready = issue_ready;

    always_comb begin
        sel_rd   = gnt_lsu ? bus.lsu_rd   : bus.exu_rd;
        sel_data = gnt_lsu ? bus.lsu_data : bus.exu_data;
        // x0 results are accepted but never written.
        rf_we_d  = xfer && (sel_rd != '0);
        rf_wa_d  = xfer ? sel_rd   : rf_wa_q;
        rf_wd_d  = xfer ? sel_data : rf_wd_q;
    end

    // Clear first, then set, so a same-edge set of the written index wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_wa_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            busy_q  <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rf_we = rf_we_q;
    assign bus.rf_wa = rf_wa_q;
    assign bus.rf_wd = rf_wd_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: the posedge passes, outputs are sampled at the negedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.exu_valid   = 1'b0; bus.exu_rd   = '0; bus.exu_data = '0;
        bus.lsu_valid   = 1'b0; bus.lsu_rd   = '0; bus.lsu_data = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();

        // Reset: outputs cleared, readies low even with requests present
        #2;
        bus.exu_valid = 1'b1; bus.lsu_valid = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        #1;
        check("rst_exu_ready",   32'(bus.exu_ready),   32'd0);
        check("rst_lsu_ready",   32'(bus.lsu_ready),   32'd0);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        check("rst_rf_we",       32'(bus.rf_we),       32'd0);
        check("rst_rf_wa",       32'(bus.rf_wa),       32'd0);
        check("rst_rf_wd",       bus.rf_wd,            32'd0);
        check("rst_busy",        bus.busy,             32'd0);
        idle_inputs();
        step(); step();
        rst_n = 1'b1;

        // Contention after reset: EXU first, then alternation
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 32'h11;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h22;
        #1;
        check("cont0_exu_ready", 32'(bus.exu_ready), 32'd1);
        check("cont0_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        step();
        check("cont1_rf_we", 32'(bus.rf_we), 32'd1);
        check("cont1_rf_wa", 32'(bus.rf_wa), 32'd3);
        check("cont1_rf_wd", bus.rf_wd,      32'h11);
        check("cont1_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        check("cont1_exu_ready", 32'(bus.exu_ready), 32'd0);
        step();
        check("cont2_rf_wa", 32'(bus.rf_wa), 32'd4);
        check("cont2_rf_wd", bus.rf_wd,      32'h22);
        check("cont2_exu_ready", 32'(bus.exu_ready), 32'd1);
        step();
        check("cont3_rf_wa", 32'(bus.rf_wa), 32'd3);
        check("cont3_rf_we", 32'(bus.rf_we), 32'd1);
        idle_inputs();
        step();
        check("cont_idle_rf_we", 32'(bus.rf_we), 32'd0);

        // Single EXU write to a non-busy register
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEADBEEF;
        #1;
        check("exu_ready", 32'(bus.exu_ready), 32'd1);
        check("exu_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        step();
        idle_inputs();
        check("exu_rf_we", 32'(bus.rf_we), 32'd1);
        check("exu_rf_wa", 32'(bus.rf_wa), 32'd5);
        check("exu_rf_wd", bus.rf_wd,      32'hDEADBEEF);
        check("exu_busy",  bus.busy,       32'd0);
        step();
        check("exu_after_rf_we", 32'(bus.rf_we), 32'd0);

        // x0 result from LSU: accepted, no write
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFFFFFF;
        #1;
        check("x0_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        step();
        idle_inputs();
        check("x0_rf_we", 32'(bus.rf_we), 32'd0);

        // Scoreboard set / stall / clear / re-issue
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        #1;
        check("sb_issue7_ready", 32'(bus.issue_ready), 32'd1);
        step();
        check("sb_busy7_set", bus.busy, 32'h80);
        check("sb_issue7_stall", 32'(bus.issue_ready), 32'd0);
        step();
        check("sb_busy7_held", bus.busy, 32'h80);
        bus.issue_rd = 5'd0;
        #1;
        check("sb_issue0_ready", 32'(bus.issue_ready), 32'd1);
        step();
        check("sb_issue0_nochange", bus.busy, 32'h80);
        idle_inputs();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h77;
        step();
        idle_inputs();
        check("sb_wr7_rf_we", 32'(bus.rf_we), 32'd1);
        check("sb_wr7_rf_wa", 32'(bus.rf_wa), 32'd7);
        check("sb_busy7_during_wr", bus.busy, 32'h80);
        step();
        check("sb_busy7_clear", bus.busy, 32'd0);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        #1;
        check("sb_reissue7_ready", 32'(bus.issue_ready), 32'd1);
        idle_inputs();

        // Same-edge set and clear of index 9: set wins
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h99;
        step();
        idle_inputs();
        check("col_rf_wa", 32'(bus.rf_wa), 32'd9);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        #1;
        check("col_issue_ready", 32'(bus.issue_ready), 32'd1);
        step();
        idle_inputs();
        check("col_busy9_kept", bus.busy, 32'h200);
        check("col_rf_we_idle", 32'(bus.rf_we), 32'd0);
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h9A;
        step();
        idle_inputs();
        step();
        check("col_busy9_clear", bus.busy, 32'd0);

        // Back-to-back EXU writes, one per cycle
        for (int i = 0; i < 4; i++) begin
            bus.exu_valid = 1'b1;
            bus.exu_rd    = 5'(10 + i);
            bus.exu_data  = 32'h1000 + 32'(i);
            #1;
            check("b2b_exu_ready", 32'(bus.exu_ready), 32'd1);
            step();
            check("b2b_rf_we", 32'(bus.rf_we), 32'd1);
            check("b2b_rf_wa", 32'(bus.rf_wa), 32'(10 + i));
            check("b2b_rf_wd", bus.rf_wd,      32'h1000 + 32'(i));
        end
        idle_inputs();
        step();
        check("b2b_tail_rf_we", 32'(bus.rf_we), 32'd0);

        // Reset in the middle of an operation
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
        step();
        idle_inputs();
        check("mid_busy12", bus.busy, 32'h1000);
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd6; bus.exu_data = 32'h66;
        @(posedge clk);
        #1;
        check("mid_rf_we_before", 32'(bus.rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rf_we",     32'(bus.rf_we),     32'd0);
        check("mid_rf_wa",     32'(bus.rf_wa),     32'd0);
        check("mid_rf_wd",     bus.rf_wd,          32'd0);
        check("mid_busy",      bus.busy,           32'd0);
        check("mid_exu_ready", 32'(bus.exu_ready), 32'd0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        check("mid_release_rf_we", 32'(bus.rf_we), 32'd0);
        check("mid_release_busy",  bus.busy,       32'd0);

        // After reset the EXU wins contention and transfers on the first edge
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd6; bus.exu_data = 32'h66;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd8; bus.lsu_data = 32'h88;
        #1;
        check("post_exu_ready", 32'(bus.exu_ready), 32'd1);
        check("post_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        step();
        idle_inputs();
        check("post_rf_we", 32'(bus.rf_we), 32'd1);
        check("post_rf_wa", 32'(bus.rf_wa), 32'd6);
        check("post_rf_wd", bus.rf_wd,      32'h66);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
